// File: rtl/pkt_credit_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pkt_credit_arb_if                                                 |
// | Brief  : Channel-side and sub-system-side signal bundle of pkt_credit_arb. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface pkt_credit_arb_if #(
    parameter int NUM_CH    = 4,
    parameter int DATA_SIZE = 64,
    parameter int ID        = 2,
    parameter int CREDITS   = 16
);
    localparam int C_BEAT_W = DATA_SIZE + ID + 1;
    localparam int C_CNT_W  = $clog2(CREDITS + 1);

    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH*C_BEAT_W-1:0] in_bus;
    logic [NUM_CH-1:0]          in_ready;
    logic                       credit_ret;
    logic                       out_valid;
    logic [C_BEAT_W-1:0]        sub_sys_bus;
    logic [C_CNT_W-1:0]         credit_cnt;
    logic                       err;
    logic [1:0]                 err_code;

    modport master (
        output in_valid, in_bus, credit_ret,
        input  in_ready, out_valid, sub_sys_bus, credit_cnt, err, err_code
    );

    modport slave (
        input  in_valid, in_bus, credit_ret,
        output in_ready, out_valid, sub_sys_bus, credit_cnt, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/pkt_credit_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pkt_credit_arb                                                    |
// | Brief  : Round-robin, packet-locked, credit-flow-controlled N:1 arbiter.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pkt_credit_arb #(
    parameter int NUM_CH        = 4,
    parameter int DATA_SIZE     = 64,
    parameter int ID            = 2,
    parameter int EOP           = 1,
    parameter int CTL_SIZE      = ID + EOP,
    parameter int CREDITS       = 16,
    parameter int MAX_PKT_BEATS = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pkt_credit_arb_if.slave  bus
);
    localparam int C_BEAT_W = DATA_SIZE + CTL_SIZE;
    localparam int C_CNT_W  = $clog2(CREDITS + 1);
    localparam int C_BCNT_W = $clog2(MAX_PKT_BEATS + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ID-1:0]         r_owner, w_owner_nxt;
    logic [ID-1:0]         r_last_grant, w_last_grant_nxt;
    logic [C_BCNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic [C_CNT_W-1:0]    r_credit_cnt;
    logic                  r_out_valid;
    logic [C_BEAT_W-1:0]   r_out_bus;
    logic                  r_err;
    logic [1:0]            r_err_code;

    logic [DATA_SIZE-1:0]  w_data_arr [NUM_CH];
    logic [NUM_CH-1:0]     w_eop_arr;
    logic [NUM_CH-1:0]     w_unused_id;
    logic [ID-1:0]         w_sel;
    logic                  w_sel_vld;
    logic [NUM_CH-1:0]     w_ready;
    logic                  w_accept;
    logic                  w_too_long;
    logic                  w_out_eop;
    logic                  w_ovf;

    // The id field of incoming beats carries no meaning; the owner index replaces it.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
        assign w_data_arr[g]  = bus.in_bus[g*C_BEAT_W + CTL_SIZE +: DATA_SIZE];
        assign w_eop_arr[g]   = bus.in_bus[g*C_BEAT_W];
        assign w_unused_id[g] = ^bus.in_bus[g*C_BEAT_W + 1 +: ID];
    end

    // Idle search runs from last_grant+1 with wrap; smallest offset wins.
    always_comb begin
        int v_idx;
        w_sel     = '0;
        w_sel_vld = 1'b0;
        v_idx     = 0;
        if (r_state == ST_LOCKED) begin
            w_sel     = r_owner;
            w_sel_vld = 1'b1;
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                v_idx = (int'(r_last_grant) + k) % NUM_CH;
                if (bus.in_valid[v_idx]) begin
                    w_sel     = ID'(v_idx);
                    w_sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (rst && w_sel_vld && (r_credit_cnt != '0)) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    assign w_accept   = |(bus.in_valid & w_ready);
    assign w_too_long = w_accept && !w_eop_arr[w_sel]
                        && (r_beat_cnt == C_BCNT_W'(MAX_PKT_BEATS - 1));
    assign w_out_eop  = w_eop_arr[w_sel] | w_too_long;
    assign w_ovf      = bus.credit_ret && !w_accept
                        && (r_credit_cnt == C_CNT_W'(CREDITS));

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_out_eop) begin
                        w_last_grant_nxt = w_sel;
                    end else begin
                        w_state_nxt    = ST_LOCKED;
                        w_owner_nxt    = w_sel;
                        w_beat_cnt_nxt = C_BCNT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    if (w_out_eop) begin
                        w_state_nxt      = ST_IDLE;
                        w_last_grant_nxt = r_owner;
                        w_beat_cnt_nxt   = '0;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + C_BCNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_grant <= ID'(NUM_CH - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_bus   <= '0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_bus <= {w_data_arr[w_sel], w_sel, w_out_eop};
            end
        end
    end

    // A return that would exceed the pool is dropped and flagged instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit_cnt <= C_CNT_W'(CREDITS);
        end else if (w_accept && !bus.credit_ret) begin
            r_credit_cnt <= r_credit_cnt - C_CNT_W'(1);
        end else if (!w_accept && bus.credit_ret && !w_ovf) begin
            r_credit_cnt <= r_credit_cnt + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else if (!r_err && (w_ovf || w_too_long)) begin
            r_err      <= 1'b1;
            r_err_code <= w_ovf ? 2'b01 : 2'b10;
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.sub_sys_bus = r_out_bus;
    assign bus.credit_cnt  = r_credit_cnt;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;
endmodule
`default_nettype wire

// File: tb/tb_pkt_credit_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_pkt_credit_arb                                                 |
// | Brief  : Directed self-checking bench for pkt_credit_arb.                  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pkt_credit_arb;
    localparam int C_BW = 67;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pkt_credit_arb_if #(.NUM_CH(4), .DATA_SIZE(64), .ID(2), .CREDITS(16)) bus ();

    pkt_credit_arb #(
        .NUM_CH(4), .DATA_SIZE(64), .ID(2), .EOP(1), .CTL_SIZE(3),
        .CREDITS(16), .MAX_PKT_BEATS(16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [C_BW-1:0] ob(input logic [63:0] d, input logic [1:0] id, input logic eop);
        return {d, id, eop};
    endfunction

    // Inputs carry a junk id of 2'b11 so that the stamped owner id is visible.
    task automatic set_ch(input int ch, input logic [63:0] d, input logic eop);
        bus.in_bus[ch*C_BW +: C_BW] = {d, 2'b11, eop};
    endtask

    task automatic do_reset(input logic [3:0] valid_during);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.in_valid    = valid_during;
        bus.credit_ret  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_bus", bus.sub_sys_bus, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_credit", bus.credit_cnt, 16);
        check("rst_err", bus.err, 0);
        check("rst_err_code", bus.err_code, 0);
        tick();
        rst          = 1'b1;
        bus.in_valid = 4'b0000;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.in_valid   = '0;
        bus.in_bus     = '0;
        bus.credit_ret = 1'b0;
        #2 rst = 1'b0;
        do_reset(4'b0001);

        // 1: three-beat packet on ch0
        bus.in_valid = 4'b0001;
        set_ch(0, 64'hA0, 1'b0);
        @(negedge clk);
        check("t1_ready", bus.in_ready, 4'b0001);
        check("t1_idle_out", bus.out_valid, 0);
        tick();
        set_ch(0, 64'hA1, 1'b0);
        @(negedge clk);
        check("t1_b0_valid", bus.out_valid, 1);
        check("t1_b0", bus.sub_sys_bus, ob(64'hA0, 2'd0, 1'b0));
        check("t1_cred15", bus.credit_cnt, 15);
        tick();
        set_ch(0, 64'hA2, 1'b1);
        @(negedge clk);
        check("t1_b1", bus.sub_sys_bus, ob(64'hA1, 2'd0, 1'b0));
        check("t1_cred14", bus.credit_cnt, 14);
        tick();
        bus.in_valid = 4'b0000;
        @(negedge clk);
        check("t1_b2", bus.sub_sys_bus, ob(64'hA2, 2'd0, 1'b1));
        check("t1_cred13", bus.credit_cnt, 13);
        tick();
        @(negedge clk);
        check("t1_bubble_valid", bus.out_valid, 0);
        check("t1_bus_hold", bus.sub_sys_bus, ob(64'hA2, 2'd0, 1'b1));

        // 2: round-robin 1,2,3 with packet lock
        tick();
        bus.in_valid = 4'b0110;
        set_ch(1, 64'hB0, 1'b0);
        set_ch(2, 64'hC0, 1'b0);
        @(negedge clk);
        check("t2_grant1", bus.in_ready, 4'b0010);
        tick();
        bus.in_valid = 4'b1110;
        set_ch(1, 64'hB1, 1'b1);
        set_ch(3, 64'hD0, 1'b0);
        @(negedge clk);
        check("t2_lock1", bus.in_ready, 4'b0010);
        check("t2_b0", bus.sub_sys_bus, ob(64'hB0, 2'd1, 1'b0));
        tick();
        bus.in_valid = 4'b1100;
        @(negedge clk);
        check("t2_grant2", bus.in_ready, 4'b0100);
        check("t2_b1", bus.sub_sys_bus, ob(64'hB1, 2'd1, 1'b1));
        tick();
        set_ch(2, 64'hC1, 1'b1);
        @(negedge clk);
        check("t2_lock2", bus.in_ready, 4'b0100);
        check("t2_c0", bus.sub_sys_bus, ob(64'hC0, 2'd2, 1'b0));
        tick();
        bus.in_valid = 4'b1000;
        @(negedge clk);
        check("t2_grant3", bus.in_ready, 4'b1000);
        check("t2_c1", bus.sub_sys_bus, ob(64'hC1, 2'd2, 1'b1));
        tick();
        set_ch(3, 64'hD1, 1'b1);
        @(negedge clk);
        check("t2_d0", bus.sub_sys_bus, ob(64'hD0, 2'd3, 1'b0));
        tick();
        bus.in_valid = 4'b0000;
        @(negedge clk);
        check("t2_d1", bus.sub_sys_bus, ob(64'hD1, 2'd3, 1'b1));
        check("t2_cred7", bus.credit_cnt, 7);
        tick();

        // 3: drain credits mid-packet on ch0, ch1 waiting
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = (i == 0) ? 4'b0001 : 4'b0011;
            set_ch(0, 64'hE0 + 64'(i), 1'b0);
            set_ch(1, 64'h99, 1'b1);
            @(negedge clk);
            check("t3_ready_ch0", bus.in_ready, 4'b0001);
            tick();
        end
        set_ch(0, 64'hE7, 1'b0);
        @(negedge clk);
        check("t3_cred0", bus.credit_cnt, 0);
        check("t3_stall_ready", bus.in_ready, 0);
        check("t3_e6", bus.sub_sys_bus, ob(64'hE6, 2'd0, 1'b0));
        tick();
        @(negedge clk);
        check("t3_stall_valid", bus.out_valid, 0);
        check("t3_stall_ready2", bus.in_ready, 0);
        tick();
        bus.credit_ret = 1'b1;
        @(negedge clk);
        check("t3_ret_ready", bus.in_ready, 0);
        tick();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        check("t3_cred1", bus.credit_cnt, 1);
        check("t3_one_ready", bus.in_ready, 4'b0001);
        tick();
        @(negedge clk);
        check("t3_e7_valid", bus.out_valid, 1);
        check("t3_e7", bus.sub_sys_bus, ob(64'hE7, 2'd0, 1'b0));
        check("t3_restall", bus.in_ready, 0);
        tick();
        @(negedge clk);
        check("t3_restall_valid", bus.out_valid, 0);

        // 4: simultaneous accept/return, then overflow
        tick();
        bus.in_valid   = 4'b0000;
        bus.credit_ret = 1'b1;
        repeat (5) tick();
        bus.in_valid = 4'b0001;
        set_ch(0, 64'hF0, 1'b1);
        @(negedge clk);
        check("t4_cred5_pre", bus.credit_cnt, 5);
        check("t4_ready", bus.in_ready, 4'b0001);
        tick();
        bus.in_valid = 4'b0000;
        @(negedge clk);
        check("t4_cred5_post", bus.credit_cnt, 5);
        check("t4_f0", bus.sub_sys_bus, ob(64'hF0, 2'd0, 1'b1));
        repeat (11) tick();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        check("t4_cred16", bus.credit_cnt, 16);
        check("t4_no_err", bus.err, 0);
        tick();
        bus.credit_ret = 1'b1;
        tick();
        bus.credit_ret = 1'b0;
        @(negedge clk);
        check("t4_ovf_err", bus.err, 1);
        check("t4_ovf_code", bus.err_code, 2'b01);
        check("t4_ovf_cred", bus.credit_cnt, 16);

        // 5: over-long packet on ch2
        do_reset(4'b0000);
        for (int i = 0; i < 16; i++) begin
            bus.in_valid   = 4'b0100;
            bus.credit_ret = 1'b1;
            set_ch(2, 64'h200 + 64'(i), 1'b0);
            @(negedge clk);
            check("t5_ready", bus.in_ready, 4'b0100);
            if (i > 0) check("t5_beat", bus.sub_sys_bus, ob(64'h200 + 64'(i - 1), 2'd2, 1'b0));
            tick();
        end
        bus.in_valid = 4'b0110;
        set_ch(2, 64'h210, 1'b0);
        set_ch(1, 64'h11, 1'b1);
        @(negedge clk);
        check("t5_forced_eop", bus.sub_sys_bus, ob(64'h20F, 2'd2, 1'b1));
        check("t5_err", bus.err, 1);
        check("t5_err_code", bus.err_code, 2'b10);
        check("t5_rearb", bus.in_ready, 4'b0010);
        check("t5_cred", bus.credit_cnt, 16);
        tick();
        bus.in_valid = 4'b0100;
        @(negedge clk);
        check("t5_ch1", bus.sub_sys_bus, ob(64'h11, 2'd1, 1'b1));
        check("t5_ch2_again", bus.in_ready, 4'b0100);
        tick();
        set_ch(2, 64'h211, 1'b0);
        bus.credit_ret = 1'b0;
        @(negedge clk);
        check("t5_beat17", bus.sub_sys_bus, ob(64'h210, 2'd2, 1'b0));
        tick();

        // 6: asynchronous reset mid-packet
        set_ch(2, 64'h212, 1'b0);
        check("t6_pre_valid", bus.out_valid, 1);
        check("t6_pre_cred", bus.credit_cnt, 15);
        #2 rst = 1'b0;
        #1;
        check("t6_async_valid", bus.out_valid, 0);
        check("t6_async_ready", bus.in_ready, 0);
        check("t6_async_cred", bus.credit_cnt, 16);
        check("t6_async_err", bus.err, 0);
        tick();
        rst          = 1'b1;
        bus.in_valid = 4'b0001;
        set_ch(0, 64'h300, 1'b1);
        @(negedge clk);
        check("t6_new_ready", bus.in_ready, 4'b0001);
        tick();
        bus.in_valid = 4'b0000;
        @(negedge clk);
        check("t6_new_valid", bus.out_valid, 1);
        check("t6_new_beat", bus.sub_sys_bus, ob(64'h300, 2'd0, 1'b1));
        check("t6_new_cred", bus.credit_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
